// File: rtl/counter.sv
// counter: free-running modulo up-counter with registered output.
// Define COUNTER_GRAY_EN to register the Gray-coded count instead of binary.
module counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP    = 1,
  parameter longint unsigned INIT    = 0
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter: WIDTH must be in 1..32");
  end
  if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("counter: MAX_VAL must be below 2**WIDTH");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $error("counter: STEP must be in 1..MAX_VAL");
  end
  if (INIT > MAX_VAL) begin : g_bad_init
    $error("counter: INIT must not exceed MAX_VAL");
  end
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAX_VAL + 64'd1);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum, wrap;
  // One extra bit keeps count+STEP from overflowing before the wrap compare
  always_comb begin
    sum   = {1'b0, cnt_q} + STEP_W;
    wrap  = sum > MAX_W ? sum - MOD_W : sum;
    cnt_d = wrap[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= INIT_W;
    else        cnt_q <= cnt_d;
`ifdef COUNTER_GRAY_EN
  // Encoded from the next count so the Gray output has no extra latency
  logic [WIDTH-1:0] gray_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) gray_q <= INIT_W ^ (INIT_W >> 1);
    else        gray_q <= cnt_d ^ (cnt_d >> 1);
  assign value = gray_q;
`else
  assign value = cnt_q;
`endif
endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized reset/run stimulus on four counter configurations,
// checked against an arithmetic modulo reference model.
module tb_counter;
  logic       clk, rst;
  logic [7:0] v0, v2;
  logic [3:0] v1;
  logic [1:0] v3;
  int n_chk = 0, n_pass = 0;
  int unsigned mdl[4];
  localparam int unsigned MODS[4]  = '{256, 10, 256, 4};
  localparam int unsigned STEPS[4] = '{1, 3, 1, 1};
  localparam int unsigned INITS[4] = '{0, 0, 250, 0};

  counter u0 (.value(v0), .clk(clk), .reset(rst));
  counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .INIT(0)) u1 (.value(v1), .clk(clk), .reset(rst));
  counter #(.INIT(250)) u2 (.value(v2), .clk(clk), .reset(rst));
  counter #(.WIDTH(2)) u3 (.value(v3), .clk(clk), .reset(rst));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int enc(input int unsigned v);
`ifdef COUNTER_GRAY_EN
    return int'(v ^ (v >> 1));
`else
    return int'(v);
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, " u0"}, int'(v0), enc(mdl[0]));
    check({tag, " u1"}, int'(v1), enc(mdl[1]));
    check({tag, " u2"}, int'(v2), enc(mdl[2]));
    check({tag, " u3"}, int'(v3), enc(mdl[3]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl[i] = INITS[i];
  endtask

  task automatic tick(input string tag);
    logic [1:0] prev;
    prev = v3;
    @(posedge clk);
    #1;
    if (rst) for (int i = 0; i < 4; i++) mdl[i] = (mdl[i] + STEPS[i]) % MODS[i];
    check_all(tag);
`ifdef COUNTER_GRAY_EN
    if (rst) check("gray one-bit", $countones(v3 ^ prev), 1);
`endif
  endtask

  initial begin
    rst = 0;
    model_reset();
    #8 check_all("reset");
    #20 rst = 1;
    check_all("release");
    for (int i = 0; i < 5; i++) tick("first");
    check("after five", int'(v0), enc(5));
    for (int i = 0; i < 300; i++) tick("rollover");
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: for (int i = 0, n = $urandom_range(1, 30); i < n; i++) tick("run");
        1: begin
          #($urandom_range(1, 3));
          rst = 0;
          model_reset();
          #1 check_all("async reset");
          #($urandom_range(1, 3));
          rst = 1;
          check_all("short release");
          tick("resume");
        end
        default: begin
          #($urandom_range(1, 3));
          rst = 0;
          model_reset();
          #1 check_all("long reset");
          for (int i = 0, n = $urandom_range(1, 4); i < n; i++) tick("held");
          #2 rst = 1;
          check_all("long release");
          tick("resume");
        end
      endcase
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
